// File: rtl/sha256_job_arbiter_if.sv
// Context type shared with the transform, and the requester/transform handshake bundle
// that connects the job arbiter to both sides.
package sha256_pkg;
  typedef logic [7:0][31:0] ShaContext;
endpackage

interface sha256_job_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]                    req_ctx_vld;
  logic [NUM_REQ-1:0]                    req_ctx_rdy;
  sha256_pkg::ShaContext [NUM_REQ-1:0]   req_ctx;
  logic [NUM_REQ-1:0]                    req_chunk_vld;
  logic [NUM_REQ-1:0]                    req_chunk_rdy;
  logic [NUM_REQ-1:0][15:0][31:0]        req_chunk;
  logic [NUM_REQ-1:0]                    req_hash_vld;
  logic [NUM_REQ-1:0]                    req_hash_rdy;
  logic [255:0]                          req_hash;

  logic                                  xfm_ctx_vld;
  logic                                  xfm_ctx_rdy;
  sha256_pkg::ShaContext                 xfm_ctx;
  logic                                  xfm_chunk_vld;
  logic                                  xfm_chunk_rdy;
  logic [15:0][31:0]                     xfm_chunk;
  logic                                  xfm_hash_vld;
  logic                                  xfm_hash_rdy;
  logic [255:0]                          xfm_hash;

  // master: requesters plus transform (the environment); slave: the arbiter
  modport master (
    output req_ctx_vld, req_ctx, req_chunk_vld, req_chunk, req_hash_rdy,
    output xfm_ctx_rdy, xfm_chunk_rdy, xfm_hash_vld, xfm_hash,
    input  req_ctx_rdy, req_chunk_rdy, req_hash_vld, req_hash,
    input  xfm_ctx_vld, xfm_ctx, xfm_chunk_vld, xfm_chunk, xfm_hash_rdy
  );

  modport slave (
    input  req_ctx_vld, req_ctx, req_chunk_vld, req_chunk, req_hash_rdy,
    input  xfm_ctx_rdy, xfm_chunk_rdy, xfm_hash_vld, xfm_hash,
    output req_ctx_rdy, req_chunk_rdy, req_hash_vld, req_hash,
    output xfm_ctx_vld, xfm_ctx, xfm_chunk_vld, xfm_chunk, xfm_hash_rdy
  );
endinterface

// File: rtl/sha256_job_arbiter.sv
// Round-robin, whole-job arbiter sharing one sha256_transform among NUM_REQ requesters,
// with a handshake watchdog that aborts a stalled job and resets the transform.
module sha256_job_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sha256_job_arbiter_if.slave  bus,
  output logic [NUM_REQ-1:0]   req_err,
  output logic                 xfm_rst,
  output logic [ID_W-1:0]      owner_id,
  output logic                 busy,
  output logic [CNT_W-1:0]     job_chunks
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, RETURN, ABORT} state_t;

  state_t               state, state_nxt;
  logic [ID_W-1:0]      rr;
  logic [ID_W-1:0]      rr_next;
  logic [ID_W-1:0]      pick_id;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_found;
  int unsigned          pick_k;
  logic [WD_W-1:0]      wd;
  logic                 ctx_hs, chunk_hs, hash_hs, any_hs, wd_expire, active;
  logic [NUM_REQ-1:0]   owner_mask;

  assign owner_mask = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_id;
  assign rr_next    = (owner_id == ID_W'(NUM_REQ - 1)) ? '0 : owner_id + 1'b1;
  assign active     = (state == LOAD) || (state == STREAM) || (state == RETURN);

  // A pending hash ends chunk forwarding in the same cycle, so no chunk handshake then.
  assign ctx_hs   = (state == LOAD) && bus.req_ctx_vld[owner_id] && bus.xfm_ctx_rdy;
  assign chunk_hs = (state == STREAM) && !bus.xfm_hash_vld &&
                    bus.req_chunk_vld[owner_id] && bus.xfm_chunk_rdy;
  assign hash_hs  = (state == RETURN) && bus.xfm_hash_vld && bus.req_hash_rdy[owner_id];
  assign any_hs   = ctx_hs || chunk_hs || hash_hs;
  assign wd_expire = active && !any_hs && (wd == WD_W'(TIMEOUT - 1));

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    pick_k     = 0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pick_k   = (32'(rr) + i) % NUM_REQ;
      pick_idx = ID_W'(pick_k);
      if (!pick_found && bus.req_ctx_vld[pick_idx]) begin
        pick_found = 1'b1;
        pick_id    = pick_idx;
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    busy              = 1'b0;
    req_err           = '0;
    xfm_rst           = 1'b0;
    bus.req_ctx_rdy   = '0;
    bus.req_chunk_rdy = '0;
    bus.req_hash_vld  = '0;
    bus.req_hash      = '0;
    bus.xfm_ctx_vld   = 1'b0;
    bus.xfm_chunk_vld = 1'b0;
    bus.xfm_hash_rdy  = 1'b0;
    bus.xfm_ctx       = bus.req_ctx[owner_id];
    bus.xfm_chunk     = bus.req_chunk[owner_id];
    case (state)
      IDLE: if (pick_found) state_nxt = LOAD;
      LOAD: begin
        busy            = 1'b1;
        bus.xfm_ctx_vld = bus.req_ctx_vld[owner_id];
        bus.req_ctx_rdy = owner_mask & {NUM_REQ{bus.xfm_ctx_rdy}};
        if (ctx_hs) state_nxt = STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        if (bus.xfm_hash_vld) begin
          state_nxt = RETURN;
        end else begin
          bus.xfm_chunk_vld = bus.req_chunk_vld[owner_id];
          bus.req_chunk_rdy = owner_mask & {NUM_REQ{bus.xfm_chunk_rdy}};
        end
      end
      RETURN: begin
        busy             = 1'b1;
        bus.req_hash     = bus.xfm_hash;
        bus.req_hash_vld = owner_mask & {NUM_REQ{bus.xfm_hash_vld}};
        bus.xfm_hash_rdy = bus.req_hash_rdy[owner_id];
        if (hash_hs) state_nxt = IDLE;
      end
      ABORT: begin
        xfm_rst   = 1'b1;
        req_err   = owner_mask;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (wd_expire) state_nxt = ABORT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr         <= '0;
      owner_id   <= '0;
      job_chunks <= '0;
      wd         <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_found) begin
        owner_id   <= pick_id;
        job_chunks <= '0;
        wd         <= '0;
      end
      if (hash_hs || state == ABORT) rr <= rr_next;
      if (chunk_hs && job_chunks != '1) job_chunks <= job_chunks + 1'b1;
      if (any_hs) wd <= '0;
      else if (active) wd <= wd + 1'b1;
    end
  end
endmodule

// File: doc/sha256_job_arbiter.md
Name: sha256_job_arbiter

Overview:
- Shares one sha256_transform instance among NUM_REQ independent hash requesters.
- Grants the transform to one requester per whole job: context load, chunk stream, hash return. Grants are round-robin.
- Sits between the requester-side job sources (nonce generators, message feeders) and the transform's ctx/chunk/hash handshakes.
- Provides a watchdog that resets a stalled transform and reports the fault to the owning requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of grant/owner id.
- TIMEOUT, 1024, maximum cycles without any handshake on the transform before abort.
- CNT_W, 16, width of per-job chunk counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_ctx_vld  in  NUM_REQ  per-requester context valid (job request).
- req_ctx_rdy  out  NUM_REQ  per-requester context accepted.
- req_ctx  in  NUM_REQ x sha256_pkg::ShaContext  per-requester context.
- req_chunk_vld  in  NUM_REQ  per-requester chunk valid.
- req_chunk_rdy  out  NUM_REQ  per-requester chunk ready.
- req_chunk  in  NUM_REQ x 512  per-requester chunk ([15:0][31:0]).
- req_hash_vld  out  NUM_REQ  hash valid, asserted only for owner.
- req_hash_rdy  in  NUM_REQ  hash ready.
- req_hash  out  256  shared hash bus.
- req_err  out  NUM_REQ  one-cycle watchdog abort pulse to owner.
- xfm_ctx_vld / xfm_ctx_rdy / xfm_ctx  out/in/out  1/1/ShaContext  transform context port.
- xfm_chunk_vld / xfm_chunk_rdy / xfm_chunk  out/in/out  1/1/512  transform chunk port.
- xfm_hash_vld / xfm_hash_rdy / xfm_hash  in/out/in  1/1/256  transform hash port.
- xfm_rst  out  1  synchronous reset request to transform (watchdog).
- owner_id  out  ID_W  current owner; valid when busy=1.
- busy  out  1  job in progress.
- job_chunks  out  CNT_W  chunks forwarded in the current or last job.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; rr pointer = 0.
  - All vld/rdy outputs = 0; req_err = 0; xfm_rst = 0; busy = 0; owner_id = 0; job_chunks = 0; req_hash = 0; watchdog = 0.
- States: IDLE, LOAD, STREAM, RETURN, ABORT.
- IDLE:
  - Pick the first asserted req_ctx_vld, searching from rr pointer upward with wrap.
  - Register owner_id; busy=1; job_chunks=0; go to LOAD the next cycle.
  - No request: stay in IDLE.
  - Arbitration is 1 cycle; no combinational path from req_ctx_vld to xfm_ctx_vld.
- LOAD:
  - xfm_ctx = req_ctx[owner]; xfm_ctx_vld = req_ctx_vld[owner].
  - req_ctx_rdy[owner] = xfm_ctx_rdy; all other req_ctx_rdy = 0.
  - On handshake go to STREAM.
- STREAM:
  - Combinational pass-through for the owner only: xfm_chunk = req_chunk[owner], xfm_chunk_vld = req_chunk_vld[owner], req_chunk_rdy[owner] = xfm_chunk_rdy.
  - Each chunk handshake increments job_chunks, saturating at all-ones.
  - xfm_hash_vld=1: go to RETURN; chunk forwarding stops that cycle.
- RETURN:
  - req_hash = xfm_hash; req_hash_vld[owner] = xfm_hash_vld; xfm_hash_rdy = req_hash_rdy[owner].
  - On handshake: rr pointer = owner+1 mod NUM_REQ; busy=0; go to IDLE.
  - Back-to-back jobs: next grant no earlier than 1 cycle after the hash handshake.
- Watchdog:
  - Counts cycles in LOAD/STREAM/RETURN; clears on any xfm ctx/chunk/hash handshake.
  - Reaching TIMEOUT: go to ABORT.
- ABORT (1 cycle):
  - xfm_rst=1; req_err[owner]=1.
  - rr pointer = owner+1; busy=0; go to IDLE.
  - Any handshake in flight is dropped.
- Non-owners see rdy=0 and hash_vld=0 at all times. Their vld may stay asserted; requests are held, never lost.
- Simultaneous request and release: the releasing requester's new request is considered only after the others, due to pointer advance.
- Requester dropping ctx_vld in LOAD: permitted; arbiter waits (watchdog applies).
- Reset mid-job: immediate return to IDLE. The transform has its own reset, so xfm_rst is not asserted.

Test Plan:
- Single request on req 2, 3 chunks, hash 0xBA7816BF… → owner_id=2, job_chunks=3, req_hash_vld[2] with req_hash equal to xfm_hash; other rdy stay 0.
- All 4 requesters continuously requesting, 1-chunk jobs → grant order 0,1,2,3,0; no requester granted twice before the others.
- Req 1 finishes while req 1 and req 3 are both pending → next owner=3.
- req_hash_rdy[owner] held low 20 cycles → hash held stable, state stays RETURN, no new grant.
- TIMEOUT=16, transform never raises xfm_chunk_rdy → on cycle 16: xfm_rst=1 and req_err[owner]=1 for one cycle, busy=0, next requester granted.
- rst asserted mid-STREAM after 2 chunks → outputs zero asynchronously; after release the first grant starts from req 0 with job_chunks=0.
